// File: rtl/mem_scan_reader_pkg.sv
// Shared types for the RAM scan reader: FSM states, stream beat layout and skid FIFO sizing.
package mem_scan_pkg;
  localparam int SCAN_ADDR_W = 4;
  localparam int SCAN_DATA_W = 8;
  localparam int FIFO_DEPTH  = 2;
  localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [SCAN_DATA_W-1:0] data;
    logic [SCAN_ADDR_W-1:0] addr;
    logic                   last;
  } beat_t;
endpackage

// File: rtl/mem_scan_reader_skid_fifo.sv
// Two-entry skid FIFO for scan beats; the head entry is the registered output beat.
module scan_skid_fifo
  import mem_scan_pkg::*;
#(
  parameter type item_t = beat_t
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  item_t                 push_item,
  input  logic                  pop,
  output item_t                 head,
  output logic                  valid,
  output logic [FIFO_CNT_W-1:0] count
);
  localparam logic [FIFO_CNT_W-1:0] CNT_ZERO = FIFO_CNT_W'(0);
  localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = FIFO_CNT_W'(1);
  localparam logic [FIFO_CNT_W-1:0] CNT_TWO  = FIFO_CNT_W'(FIFO_DEPTH);

  item_t                 head_r, tail_r, head_n, tail_n;
  logic [FIFO_CNT_W-1:0] count_r, count_n;
  logic                  valid_r;
  logic                  pop_ok_s;

  assign pop_ok_s = pop && (count_r != CNT_ZERO);

  // Next-state for the two entries; a push into a full FIFO without a pop is dropped.
  always_comb begin
    head_n  = head_r;
    tail_n  = tail_r;
    count_n = count_r;
    if (flush) begin
      count_n = CNT_ZERO;
    end else begin
      case ({push, pop_ok_s})
        2'b10: begin
          if (count_r == CNT_ZERO) begin
            head_n  = push_item;
            count_n = CNT_ONE;
          end else if (count_r == CNT_ONE) begin
            tail_n  = push_item;
            count_n = CNT_TWO;
          end else begin
            count_n = count_r;
          end
        end
        2'b01: begin
          head_n  = tail_r;
          count_n = count_r - CNT_ONE;
        end
        2'b11: begin
          if (count_r == CNT_ONE) begin
            head_n = push_item;
          end else begin
            head_n = tail_r;
            tail_n = push_item;
          end
        end
        default: count_n = count_r;
      endcase
    end
  end

  // Entry, occupancy and valid registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= CNT_ZERO;
      valid_r <= 1'b0;
    end else begin
      head_r  <= head_n;
      tail_r  <= tail_n;
      count_r <= count_n;
      valid_r <= (count_n != CNT_ZERO);
    end
  end

  assign head  = head_r;
  assign valid = valid_r;
  assign count = count_r;
endmodule

// File: rtl/mem_scan_reader.sv
// Sweeps a synchronous RAM and streams each cell as an address-tagged ready/valid beat.
// Optional SCAN_CHECKSUM_EN adds out_sum, the modulo-2**DATA_W sum of the current pass.
module mem_scan_reader
  import mem_scan_pkg::*;
#(
  parameter int ADDR_W = SCAN_ADDR_W,
  parameter int DATA_W = SCAN_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              loop,
  input  logic              hold,
  input  logic              abort,
  output logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef SCAN_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] out_sum
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } lane_beat_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam int                OCC_W     = FIFO_CNT_W + 1;
  localparam logic [OCC_W-1:0]  DEPTH_C   = OCC_W'(FIFO_DEPTH);

  scan_state_t           state_r;
  logic [ADDR_W-1:0]     issue_addr_r, a_r, s2_addr_r;
  logic                  s1_r, s2_r, busy_r, done_r;
  lane_beat_t            push_beat_s, head_s;
  logic                  fifo_valid_s;
  logic [FIFO_CNT_W-1:0] count_s;
  logic [OCC_W-1:0]      room_used_s, pending_s;
  logic                  pop_s, push_s, can_issue_s, issue_s, drain_done_s;

  // s1: read issued, RAM still sampling; s2: its data sits on dout. While no newer
  // read is issued, a holds and dout keeps the s2 data, so dout acts as a third slot.
  always_comb begin
    pop_s        = fifo_valid_s && out_ready;
    room_used_s  = OCC_W'(count_s) - OCC_W'(pop_s);
    push_s       = s2_r && (room_used_s < DEPTH_C) && !abort;
    pending_s    = OCC_W'(s1_r) + OCC_W'(s2_r && !push_s);
    can_issue_s  = !hold && !abort && ((room_used_s + pending_s) < DEPTH_C);
    case (state_r)
      IDLE:    issue_s = start && can_issue_s;
      ISSUE:   issue_s = can_issue_s;
      default: issue_s = 1'b0;
    endcase
    drain_done_s = (state_r == DRAIN) && (room_used_s == OCC_W'(0)) &&
                   !s1_r && !s2_r && !abort;
  end

  assign push_beat_s.data = dout;
  assign push_beat_s.addr = s2_addr_r;
  assign push_beat_s.last = (s2_addr_r == LAST_ADDR);

  scan_skid_fifo #(
    .item_t(lane_beat_t)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (abort),
    .push     (push_s),
    .push_item(push_beat_s),
    .pop      (pop_s),
    .head     (head_s),
    .valid    (fifo_valid_s),
    .count    (count_s)
  );

  // Pass sequencing, read issue and in-flight read tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      issue_addr_r <= {ADDR_W{1'b0}};
      a_r          <= {ADDR_W{1'b0}};
      s2_addr_r    <= {ADDR_W{1'b0}};
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else if (abort) begin
      state_r      <= IDLE;
      issue_addr_r <= {ADDR_W{1'b0}};
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= drain_done_s;
      s1_r   <= issue_s;
      if (s1_r) begin
        s2_r      <= 1'b1;
        s2_addr_r <= a_r;
      end else if (push_s) begin
        s2_r <= 1'b0;
      end
      if (issue_s) begin
        a_r          <= issue_addr_r;
        issue_addr_r <= issue_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= ISSUE;
            busy_r  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_s && (issue_addr_r == LAST_ADDR)) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done_s) begin
            if (loop) begin
              state_r <= ISSUE;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] sum_r;
  logic              sum_clear_s;

  // A looping pass clears one cycle after done so the done cycle still shows the total.
  assign sum_clear_s = ((state_r == IDLE) && start) || (done_r && (state_r == ISSUE));

  // Running sum of accepted beats for the current pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_r <= {DATA_W{1'b0}};
    end else if (abort) begin
      sum_r <= sum_r;
    end else if (sum_clear_s) begin
      sum_r <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      sum_r <= sum_r + head_s.data;
    end
  end

  assign out_sum = sum_r;
`endif

  assign a         = a_r;
  assign out_data  = head_s.data;
  assign out_addr  = head_s.addr;
  assign out_last  = head_s.last;
  assign out_valid = fifo_valid_s;
  assign busy      = busy_r;
  assign done      = done_r;
endmodule

// File: tb/tb_mem_scan_reader.sv
// Directed bench for mem_scan_reader with a behavioural 16x8 registered-read RAM.
module tb_mem_scan_reader;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, loop = 1'b0, hold = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [3:0] a, out_addr;
  logic [7:0] dout, out_data;
  logic       out_last, out_valid, busy, done;
`ifdef SCAN_CHECKSUM_EN
  logic [7:0] out_sum;
`endif
  logic [7:0] mem [16];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) dout <= mem[a];

  mem_scan_reader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .loop     (loop),
    .hold     (hold),
    .abort    (abort),
    .a        (a),
    .dout     (dout),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
`ifdef SCAN_CHECKSUM_EN
    ,
    .out_sum  (out_sum)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a"}, a, 0);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_data"}, out_data, 0);
    check_eq({tag, "_addr"}, out_addr, 0);
    check_eq({tag, "_last"}, out_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
`ifdef SCAN_CHECKSUM_EN
    check_eq({tag, "_sum"}, out_sum, 0);
`endif
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: hold for cycles 3..8; 3: loop for two passes.
  // Iteration c samples just after edge k+c, where edge k sampled start.
  task automatic collect(input int mode, input int n_pass, input int exp_first, input int exp_done_c);
    int         beats = 0;
    int         dones = 0;
    int         first_c = -1;
    int         done_c = -1;
    logic       stalled = 1'b0;
    logic [7:0] st_data = 8'h00;
    logic [3:0] st_addr = 4'h0;
    logic [7:0] exp_sum = 8'h00;
    logic [3:0] ea;
    logic [7:0] ed;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        dones++;
        check_eq("pass_beats", beats, 16 * dones);
`ifdef SCAN_CHECKSUM_EN
        check_eq("out_sum", out_sum, exp_sum);
`endif
        exp_sum = 8'h00;
        if (dones == n_pass) begin
          done_c = c;
          break;
        end
      end else begin
        check_eq("busy_in_pass", busy, 1);
      end
      if (stalled) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, st_data);
        check_eq("stall_addr", out_addr, st_addr);
      end
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        check_eq("reads_ahead", (4'(a - out_addr) <= 4'd2), 1);
      end
      out_ready = (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      hold      = (mode == 2) && (c >= 3) && (c <= 8);
      loop      = (mode == 3) && (dones < 2);
      if (out_valid && out_ready) begin
        ea = 4'(beats);
        ed = 8'h10 + {4'h0, ea};
        check_eq("beat_addr", out_addr, ea);
        check_eq("beat_data", out_data, ed);
        check_eq("beat_last", out_last, (ea == 4'hF));
        exp_sum = exp_sum + ed;
        beats++;
      end
      stalled = out_valid && !out_ready;
      st_data = out_data;
      st_addr = out_addr;
      step();
    end
    hold = 1'b0;
    loop = 1'b0;
    check_eq("passes", dones, n_pass);
    check_eq("beats_total", beats, 16 * n_pass);
    if (exp_first >= 0) check_eq("first_valid_cycle", first_c, exp_first);
    if (exp_done_c >= 0) check_eq("done_cycle", done_c, exp_done_c);
    check_eq("end_valid", out_valid, 0);
    check_eq("end_busy", busy, 0);
    step();
    check_eq("done_one_cycle", done, 0);
  endtask

  task automatic start_pass();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    step();
    step();
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_eq("idle_busy", busy, 0);

    // Basic pass: first beat two cycles after start, done after the sixteenth.
    start_pass();
    collect(0, 1, 2, 18);
    step();

    // Backpressure pattern.
    start_pass();
    collect(1, 1, -1, -1);
    step();

    // Read issue held for six cycles: six extra cycles to done.
    start_pass();
    collect(2, 1, 2, 24);
    step();

    // Loop for two passes, third pass ends the run.
    loop = 1'b1;
    start_pass();
    collect(3, 3, 2, 56);
    step();

    // Abort colliding with start.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("collide_busy", busy, 0);
    check_eq("collide_valid", out_valid, 0);
    step();
    step();
    check_eq("collide_valid_later", out_valid, 0);
    check_eq("collide_busy_later", busy, 0);

    // Abort when beat 7 is presented.
    out_ready = 1'b1;
    start_pass();
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && (out_addr == 4'd7)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_eq("reach_beat7", found, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("abort_no_done", done, 0);
      check_eq("abort_stay_idle", out_valid, 0);
    end

    // Fresh start after abort restarts at address 0.
    start_pass();
    collect(0, 1, 2, 18);
    step();

    // Asynchronous reset mid-pass.
    start_pass();
    for (int c = 0; c < 5; c++) step();
    check_eq("pre_reset_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_eq("post_reset_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
